// File: rtl/skeleton_math_sequencer.sv
// skeleton_math_sequencer
// Host-side sequencer for the single-cycle math test skeleton. It takes an
// operand pair {B, A} from a valid/ready stream and writes A to address 0 and
// B to address 1. It then pulses the start trigger and waits for the
// skeleton's RDY flag, with a timeout guard. The captured result word, or a
// timeout error, is returned on a valid/ready result stream.
module skeleton_math_sequencer #(
   parameter int BITWIDTH_IN  = 8,
   parameter int BITWIDTH_SYS = 16,
   parameter int BITWIDTH_ADR = 6,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic                     CLK_SYS,
   input  logic                     RST,
   input  logic                     EN,
   input  logic                     S_VALID,
   output logic                     S_READY,
   input  logic [2*BITWIDTH_IN-1:0] S_DATA,
   output logic                     M_VALID,
   input  logic                     M_READY,
   output logic [BITWIDTH_SYS-1:0]  M_DATA,
   output logic                     M_ERR,
   output logic                     SKL_EN,
   output logic                     SKL_TRGG,
   output logic                     SKL_RNW,
   output logic [BITWIDTH_ADR-1:0]  SKL_ADR,
   output logic [BITWIDTH_SYS-1:0]  SKL_DATA_IN,
   input  logic [BITWIDTH_SYS-1:0]  SKL_DATA_OUT,
   input  logic                     SKL_RDY,
   output logic                     BUSY,
   output logic [15:0]              CNT_DONE
);

   localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      TRIG,
      WAIT_BUSY,
      WAIT_RDY,
      ABORT,
      OUT
   } state_t;

   state_t                 state;
   logic [BITWIDTH_IN-1:0] op_a;
   logic [BITWIDTH_IN-1:0] op_b;
   logic [CW-1:0]          tmo_cnt;

   // Sequencer FSM: operand latch, timeout counting, result capture and done counter
   always_ff @(posedge CLK_SYS or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         tmo_cnt  <= '0;
         M_DATA   <= '0;
         M_ERR    <= 1'b0;
         CNT_DONE <= '0;
      end else if (!EN) begin
         // Any pending result is dropped. CNT_DONE keeps its value.
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (S_VALID) begin
                  op_a  <= S_DATA[BITWIDTH_IN-1:0];
                  op_b  <= S_DATA[2*BITWIDTH_IN-1:BITWIDTH_IN];
                  state <= WR_A;
               end
            end
            WR_A: state <= WR_B;
            WR_B: state <= TRIG;
            TRIG: begin
               tmo_cnt <= '0;
               state   <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // The counter restarts on entry to WAIT_RDY. The RDY timeout
               // therefore counts only the cycles spent in WAIT_RDY.
               if (!SKL_RDY) begin
                  tmo_cnt <= '0;
                  state   <= WAIT_RDY;
               end else if (tmo_cnt == CW'(1)) begin
                  state <= ABORT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_RDY: begin
               if (SKL_RDY) begin
                  M_DATA <= SKL_DATA_OUT;
                  M_ERR  <= 1'b0;
                  state  <= OUT;
               end else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  state <= ABORT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ABORT: begin
               M_DATA <= '0;
               M_ERR  <= 1'b1;
               state  <= OUT;
            end
            OUT: begin
               if (M_READY) begin
                  if (!M_ERR) CNT_DONE <= CNT_DONE + 16'd1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Moore decode of the skeleton bus and stream flags from the state register
   always_comb begin
      S_READY     = 1'b0;
      SKL_TRGG    = 1'b0;
      SKL_RNW     = 1'b1;
      SKL_ADR     = '0;
      SKL_DATA_IN = '0;
      SKL_EN      = EN & ~RST;
      case (state)
         // While EN is low, S_READY is held low so that no pair is accepted and then lost.
         IDLE: S_READY = EN & ~RST;
         WR_A: begin
            SKL_RNW = 1'b0;
            SKL_DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN] = op_a;
         end
         WR_B: begin
            SKL_RNW = 1'b0;
            SKL_ADR = BITWIDTH_ADR'(1);
            SKL_DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN] = op_b;
         end
         TRIG:    SKL_TRGG = 1'b1;
         ABORT:   SKL_EN   = 1'b0;
         default: ;
      endcase
      M_VALID = (state == OUT);
      BUSY    = (state != IDLE);
   end

endmodule

// File: tb/tb_skeleton_math_sequencer.sv
// tb_skeleton_math_sequencer
// Drives operand pairs into the sequencer. A behavioural skeleton model
// multiplies the operands and can be configured to stall or to ignore the
// trigger. Each outcome is compared with the result, latency and counter
// values computed directly from the operands.
module tb_skeleton_math_sequencer;

   localparam int TMO = 16;

   logic        CLK_SYS = 1'b0;
   logic        RST;
   logic        EN;
   logic        S_VALID;
   logic        S_READY;
   logic [15:0] S_DATA;
   logic        M_VALID;
   logic        M_READY;
   logic [15:0] M_DATA;
   logic        M_ERR;
   logic        SKL_EN;
   logic        SKL_TRGG;
   logic        SKL_RNW;
   logic [5:0]  SKL_ADR;
   logic [15:0] SKL_DATA_IN;
   logic [15:0] SKL_DATA_OUT;
   logic        SKL_RDY;
   logic        BUSY;
   logic [15:0] CNT_DONE;

   skeleton_math_sequencer #(
      .BITWIDTH_IN  (8),
      .BITWIDTH_SYS (16),
      .BITWIDTH_ADR (6),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .CLK_SYS      (CLK_SYS),
      .RST          (RST),
      .EN           (EN),
      .S_VALID      (S_VALID),
      .S_READY      (S_READY),
      .S_DATA       (S_DATA),
      .M_VALID      (M_VALID),
      .M_READY      (M_READY),
      .M_DATA       (M_DATA),
      .M_ERR        (M_ERR),
      .SKL_EN       (SKL_EN),
      .SKL_TRGG     (SKL_TRGG),
      .SKL_RNW      (SKL_RNW),
      .SKL_ADR      (SKL_ADR),
      .SKL_DATA_IN  (SKL_DATA_IN),
      .SKL_DATA_OUT (SKL_DATA_OUT),
      .SKL_RDY      (SKL_RDY),
      .BUSY         (BUSY),
      .CNT_DONE     (CNT_DONE)
   );

   // 100 MHz system clock
   always #5 CLK_SYS = ~CLK_SYS;

   int cyc = 0;
   // Free-running cycle counter used for latency measurement
   always @(posedge CLK_SYS) cyc <= cyc + 1;

   // Skeleton model. Mode 0 = multiplier busy for mdl_busy cycles,
   // mode 1 = ignores the trigger, mode 2 = RDY stuck low after the trigger.
   int          mdl_mode  = 0;
   int          mdl_busy  = 5;
   int          busy_left = 0;
   bit          stuck     = 1'b0;
   logic [15:0] ram0      = '0;
   logic [15:0] ram1      = '0;
   logic [15:0] mdl_dout  = '0;

   assign SKL_RDY      = (busy_left == 0) && !stuck;
   assign SKL_DATA_OUT = mdl_dout;

   // Skeleton behaviour: cleared while its enable is low
   always @(posedge CLK_SYS) begin
      if (!SKL_EN) begin
         busy_left <= 0;
         stuck     <= 1'b0;
         ram0      <= '0;
         ram1      <= '0;
         mdl_dout  <= '0;
      end else begin
         if (!SKL_RNW && SKL_ADR == 6'd0) ram0 <= SKL_DATA_IN;
         if (!SKL_RNW && SKL_ADR == 6'd1) ram1 <= SKL_DATA_IN;
         if (SKL_TRGG) begin
            mdl_dout <= 16'hBEEF;
            if (mdl_mode == 0) busy_left <= mdl_busy;
            else if (mdl_mode == 2) stuck <= 1'b1;
         end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) mdl_dout <= 16'(ram0[15:8]) * 16'(ram1[15:8]);
         end
      end
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] cnt_exp  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK_SYS);
      #1;
   endtask

   // Waits for S_READY, then presents one pair for a single handshake cycle
   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      int waited;
      waited = 0;
      while (!S_READY && waited < 50) begin
         step();
         waited++;
      end
      check("s_ready_before_op", S_READY, 1);
      S_VALID = 1'b1;
      S_DATA  = {b, a};
      step();
      S_VALID = 1'b0;
      S_DATA  = '0;
   endtask

   // Full operation with bus, latency, result, backpressure and counter checks
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input int mode, input int busy, input int hold);
      int          t0, exp_lat, trg, en_low, sr_busy, waited;
      bit          got;
      logic        exp_err;
      logic [15:0] exp_data;
      mdl_mode = mode;
      mdl_busy = busy;
      exp_err  = (mode != 0);
      exp_data = exp_err ? 16'h0000 : 16'(a) * 16'(b);
      exp_lat  = (mode == 0) ? 5 + busy : (mode == 1) ? 7 : 6 + TMO;
      M_READY  = (hold == 0);
      waited   = 0;
      while (!S_READY && waited < 50) begin
         step();
         waited++;
      end
      check("s_ready_before_op", S_READY, 1);
      S_VALID = 1'b1;
      S_DATA  = {b, a};
      t0      = cyc;
      step();
      S_VALID = 1'b0;
      S_DATA  = '0;
      check("wr_a_rnw", SKL_RNW, 0);
      check("wr_a_adr", SKL_ADR, 0);
      check("wr_a_data", SKL_DATA_IN, {a, 8'h00});
      step();
      check("wr_b_rnw", SKL_RNW, 0);
      check("wr_b_adr", SKL_ADR, 1);
      check("wr_b_data", SKL_DATA_IN, {b, 8'h00});
      step();
      check("trig_in_cycle3", SKL_TRGG, 1);
      trg = 0; en_low = 0; sr_busy = 0; got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (M_VALID) begin
            got = 1'b1;
            break;
         end
         if (SKL_TRGG) trg++;
         if (!SKL_EN) en_low++;
         if (S_READY) sr_busy++;
         step();
      end
      check("m_valid_seen", got, 1);
      check("latency", cyc - t0, exp_lat);
      check("trig_cycles", trg, 1);
      check("skl_en_low_cycles", en_low, exp_err ? 1 : 0);
      check("s_ready_while_busy", sr_busy, 0);
      check("m_data", M_DATA, exp_data);
      check("m_err", M_ERR, exp_err);
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", M_VALID, 1);
         check("hold_data", M_DATA, exp_data);
         check("hold_s_ready", S_READY, 0);
         step();
      end
      M_READY = 1'b1;
      step();
      if (!exp_err) cnt_exp = cnt_exp + 16'd1;
      check("m_valid_after_accept", M_VALID, 0);
      check("busy_after_accept", BUSY, 0);
      check("cnt_done", CNT_DONE, cnt_exp);
   endtask

   // Four pairs with S_VALID held high; results must arrive in order, 11 cycles apart
   task automatic run_b2b();
      logic [7:0]  pa[4];
      logic [7:0]  pb[4];
      int          tv[$];
      logic [15:0] dv[$];
      mdl_mode = 0;
      mdl_busy = 5;
      M_READY  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pa[k] = 8'($urandom_range(0, 255));
         pb[k] = 8'($urandom_range(0, 255));
      end
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               bit acc;
               int g;
               S_VALID = 1'b1;
               S_DATA  = {pb[k], pa[k]};
               acc = 1'b0;
               g   = 0;
               while (!acc && g < 100) begin
                  acc = S_READY;
                  step();
                  g++;
               end
            end
            S_VALID = 1'b0;
            S_DATA  = '0;
         end
         begin
            for (int i = 0; i < 150 && tv.size() < 4; i++) begin
               if (M_VALID) begin
                  tv.push_back(cyc);
                  dv.push_back(M_DATA);
               end
               step();
            end
         end
      join
      check("b2b_count", tv.size(), 4);
      for (int k = 0; k < tv.size(); k++) begin
         check("b2b_data", dv[k], 16'(pa[k]) * 16'(pb[k]));
         if (k > 0) check("b2b_spacing", tv[k] - tv[k-1], 11);
      end
      cnt_exp = cnt_exp + 16'(tv.size());
      check("b2b_cnt_done", CNT_DONE, cnt_exp);
   endtask

   // Asserts the reset value of every output; called while RST is high
   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, S_READY, 0);
      check({tag, "_m_valid"}, M_VALID, 0);
      check({tag, "_m_err"}, M_ERR, 0);
      check({tag, "_m_data"}, M_DATA, 0);
      check({tag, "_skl_trgg"}, SKL_TRGG, 0);
      check({tag, "_skl_rnw"}, SKL_RNW, 1);
      check({tag, "_skl_adr"}, SKL_ADR, 0);
      check({tag, "_skl_data_in"}, SKL_DATA_IN, 0);
      check({tag, "_skl_en"}, SKL_EN, 0);
      check({tag, "_busy"}, BUSY, 0);
      check({tag, "_cnt_done"}, CNT_DONE, 0);
   endtask

   // Hard time limit so the run always terminates
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Main stimulus sequence
   initial begin
      int nv;
      RST = 1'b1; EN = 1'b1; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b1;
      repeat (3) @(posedge CLK_SYS);
      #1;
      check_reset_outputs("reset");
      RST = 1'b0;
      #1;
      check("s_ready_after_release", S_READY, 1);
      check("skl_en_after_release", SKL_EN, 1);
      step();

      // Basic: 3 * 5 against a 5-cycle skeleton
      run_op(8'd3, 8'd5, 0, 5, 0);
      // Backpressure for 20 cycles
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 5, 20);
      // Trigger ignored: abort after two WAIT_BUSY cycles
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, 5, 0);
      // RDY stuck low: abort after the RDY timeout
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2, 5, 0);
      // Back-to-back stream
      run_b2b();

      // EN low during WAIT_RDY
      mdl_mode = 0; mdl_busy = 8; M_READY = 1'b1;
      start_op(8'd7, 8'd9);
      repeat (5) step();
      check("en_test_busy_before", BUSY, 1);
      EN = 1'b0;
      step();
      check("en_low_busy", BUSY, 0);
      check("en_low_m_valid", M_VALID, 0);
      EN = 1'b1;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         if (M_VALID) nv++;
         step();
      end
      check("en_low_no_result", nv, 0);
      check("en_low_cnt_held", CNT_DONE, cnt_exp);

      // EN low together with M_READY while a result is pending
      M_READY = 1'b0;
      mdl_busy = 3;
      start_op(8'd11, 8'd13);
      nv = 0;
      for (int i = 0; i < 50 && !M_VALID; i++) step();
      check("en_mready_valid_seen", M_VALID, 1);
      EN = 1'b0;
      M_READY = 1'b1;
      step();
      check("en_mready_valid_drop", M_VALID, 0);
      check("en_mready_cnt_held", CNT_DONE, cnt_exp);
      EN = 1'b1;
      step();

      // RST pulse during WR_B, then a normal operation
      mdl_busy = 5;
      start_op(8'd21, 8'd2);
      step();
      check("rst_test_in_wr_b", SKL_ADR, 1);
      #2;
      RST = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      cnt_exp = '0;
      step();
      RST = 1'b0;
      step();
      run_op(8'd21, 8'd2, 0, 5, 0);

      // Randomized operations
      for (int k = 0; k < 10; k++) begin
         int r, md;
         r  = $urandom_range(0, 9);
         md = (r < 7) ? 0 : (r < 9) ? 1 : 2;
         run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), md,
                $urandom_range(1, 12), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
